// File: rtl/opb_reg_pkg.sv
// Shared definitions for the OPB register blocks:
// word indices, register bit positions, bus FSM states, bit-order helpers.
package opb_reg_pkg;

  localparam logic [1:0] IDX_DATA   = 2'd0;
  localparam logic [1:0] IDX_STATUS = 2'd1;
  localparam logic [1:0] IDX_CTRL   = 2'd2;

  localparam int ST_NEW     = 0;
  localparam int ST_OVF     = 1;
  localparam int ST_FROZEN  = 2;
  localparam int ST_CNT_LSB = 3;

  localparam int CTRL_CLR    = 0;
  localparam int CTRL_FREEZE = 1;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    HOLD
  } opb_state_t;

  // OPB numbers bit 0 as the MSB.
  function automatic logic [31:0] opb_to_reg(input logic [0:31] d);
    logic [31:0] r;
    for (int i = 0; i < 32; i++)
      r[31-i] = d[i];
    return r;
  endfunction

  function automatic logic [0:31] reg_to_opb(input logic [31:0] d);
    logic [0:31] r;
    for (int i = 0; i < 32; i++)
      r[i] = d[31-i];
    return r;
  endfunction

endpackage

// File: rtl/opb_slave_fsm.sv
// Generic OPB slave front end: window decode, IDLE/ACK/HOLD handshake,
// request latching and read-data gating for a 4-word register block.
module opb_slave_fsm
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_000F,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [0:C_OPB_AWIDTH-1] opb_abus,
  input  logic [0:C_OPB_DWIDTH-1] opb_dbus,
  input  logic                    opb_rnw,
  input  logic                    opb_select,
  input  logic [31:0]             rdata,
  output logic                    rd_stb,
  output logic                    wr_stb,
  output logic [1:0]              idx,
  output logic [31:0]             wdata,
  output logic [0:C_OPB_DWIDTH-1] sl_dbus,
  output logic                    sl_xferack
);

  localparam int IDX_POS = C_OPB_AWIDTH - 4;

  opb_state_t state_q, state_d;

  logic [C_OPB_AWIDTH:0] lo_d;
  logic [C_OPB_AWIDTH:0] hi_d;
  logic                  hit;
  logic                  rnw_q;

  // Borrow-out of the subtraction flags an address outside the window.
  assign lo_d = {1'b0, opb_abus} - {1'b0, C_BASEADDR[C_OPB_AWIDTH-1:0]};
  assign hi_d = {1'b0, C_HIGHADDR[C_OPB_AWIDTH-1:0]} - {1'b0, opb_abus};
  assign hit  = opb_select & ~lo_d[C_OPB_AWIDTH] & ~hi_d[C_OPB_AWIDTH];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hit) state_d = ACK;
      ACK:     state_d = HOLD;
      HOLD:    if (!opb_select) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx     <= '0;
      rnw_q   <= 1'b0;
      wdata   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && hit) begin
        idx   <= opb_abus[IDX_POS +: 2];
        rnw_q <= opb_rnw;
        wdata <= opb_to_reg(opb_dbus);
      end
    end
  end

  assign sl_xferack = (state_q == ACK);
  assign rd_stb     = sl_xferack & rnw_q;
  assign wr_stb     = sl_xferack & ~rnw_q;
  assign sl_dbus    = rd_stb ? reg_to_opb(rdata) : '0;

endmodule

// File: rtl/opb_register_simulink2ppc_latched.sv
// Fabric-to-PPC readback register: latched capture word with NEW flag,
// capture counter, sticky overflow and a freeze control.
module opb_register_simulink2ppc_latched
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_000F,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_CNT_WIDTH  = 16
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [31:0]             user_data_in,
  input  logic                    user_valid
);

  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = 1;

  logic                   rd_stb;
  logic                   wr_stb;
  logic [1:0]             idx;
  logic [31:0]            wdata;
  logic [31:0]            rdata;
  logic [31:0]            status;
  logic [31:0]            data_q;
  logic [C_CNT_WIDTH-1:0] cnt_q;
  logic                   new_q;
  logic                   ovf_q;
  logic                   frz_q;
  logic                   ctrl_wr;
  logic                   clr;
  logic                   data_rd;
  logic                   cap;
  logic                   new_base;
  logic                   ovf_base;
  logic [C_CNT_WIDTH-1:0] cnt_base;
  logic                   unused_ok;

  opb_slave_fsm #(
    .C_BASEADDR   (C_BASEADDR),
    .C_HIGHADDR   (C_HIGHADDR),
    .C_OPB_AWIDTH (C_OPB_AWIDTH),
    .C_OPB_DWIDTH (C_OPB_DWIDTH)
  ) u_fsm (
    .clk        (OPB_Clk),
    .rst_n      (OPB_Rst_n),
    .opb_abus   (OPB_ABus),
    .opb_dbus   (OPB_DBus),
    .opb_rnw    (OPB_RNW),
    .opb_select (OPB_select),
    .rdata      (rdata),
    .rd_stb     (rd_stb),
    .wr_stb     (wr_stb),
    .idx        (idx),
    .wdata      (wdata),
    .sl_dbus    (Sl_DBus),
    .sl_xferack (Sl_xferAck)
  );

  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign unused_ok  = ^{OPB_BE, OPB_seqAddr, wdata[31:2]};

  assign ctrl_wr = wr_stb & (idx == IDX_CTRL);
  assign clr     = ctrl_wr & wdata[CTRL_CLR];
  assign data_rd = rd_stb & (idx == IDX_DATA);
  assign cap     = user_valid & ~frz_q;

  // Clears and reads apply first; a same-cycle capture lands on top.
  assign new_base = new_q & ~data_rd & ~clr;
  assign ovf_base = ovf_q & ~clr;
  assign cnt_base = clr ? '0 : cnt_q;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
      new_q  <= 1'b0;
      ovf_q  <= 1'b0;
      frz_q  <= 1'b0;
    end else begin
      if (cap) begin
        data_q <= user_data_in;
        cnt_q  <= cnt_base + CNT_ONE;
        new_q  <= 1'b1;
        ovf_q  <= ovf_base | new_base;
      end else begin
        cnt_q  <= cnt_base;
        new_q  <= new_base;
        ovf_q  <= ovf_base;
      end
      if (ctrl_wr)
        frz_q <= wdata[CTRL_FREEZE];
    end
  end

  always_comb begin
    status                            = '0;
    status[ST_NEW]                    = new_q;
    status[ST_OVF]                    = ovf_q;
    status[ST_FROZEN]                 = frz_q;
    status[ST_CNT_LSB +: C_CNT_WIDTH] = cnt_q;
  end

  always_comb begin
    rdata = '0;
    unique case (idx)
      IDX_DATA:   rdata = data_q;
      IDX_STATUS: rdata = status;
      default:    rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_opb_register_simulink2ppc_latched.sv
// Scoreboard bench for the fabric-to-PPC readback register.
module tb_opb_register_simulink2ppc_latched;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:31] abus = '0;
  logic [0:3]  be = '1;
  logic [0:31] dbus = '0;
  logic        rnw = 1'b1;
  logic        sel = 1'b0;
  logic        seq = 1'b0;
  logic [0:31] sl_dbus;
  logic        ack;
  logic        err_ack;
  logic        retry;
  logic        tout;
  logic [31:0] udata = '0;
  logic        uvalid = 1'b0;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  opb_register_simulink2ppc_latched dut (
    .OPB_Clk      (clk),
    .OPB_Rst_n    (rst_n),
    .OPB_ABus     (abus),
    .OPB_BE       (be),
    .OPB_DBus     (dbus),
    .OPB_RNW      (rnw),
    .OPB_select   (sel),
    .OPB_seqAddr  (seq),
    .Sl_DBus      (sl_dbus),
    .Sl_xferAck   (ack),
    .Sl_errAck    (err_ack),
    .Sl_retry     (retry),
    .Sl_toutSup   (tout),
    .user_data_in (udata),
    .user_valid   (uvalid)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every ack consumes one scoreboard entry.
  always @(negedge clk) begin
    if (ack) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack=1 expected none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.rd)
          chk(e.name, sl_dbus, e.data);
      end
    end else begin
      chk("dbus_idle_zero", sl_dbus, 32'h0);
    end
  end

  task automatic xfer(input string nm, input logic [31:0] addr,
                      input bit rd, input logic [31:0] wd,
                      input logic [31:0] exp, input int hold,
                      input bit cap, input logic [31:0] cd);
    int acks;
    acks = 0;
    sb.push_back('{rd, exp, nm});
    @(negedge clk);
    abus = addr;
    rnw  = rd;
    dbus = wd;
    sel  = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (ack) acks++;
      if (i == 0) begin
        chk({nm, "_latency"}, {31'b0, ack}, 32'h1);
        if (cap) begin
          uvalid = 1'b1;
          udata  = cd;
        end
      end else begin
        uvalid = 1'b0;
      end
    end
    sel    = 1'b0;
    uvalid = 1'b0;
    rnw    = 1'b1;
    @(negedge clk);
    chk({nm, "_ack_count"}, acks, 32'd1);
  endtask

  task automatic rd(input string nm, input logic [31:0] addr,
                    input logic [31:0] exp);
    xfer(nm, addr, 1'b1, 32'h0, exp, 2, 1'b0, 32'h0);
  endtask

  task automatic wr(input string nm, input logic [31:0] addr,
                    input logic [31:0] wd);
    xfer(nm, addr, 1'b0, wd, 32'h0, 2, 1'b0, 32'h0);
  endtask

  task automatic pulse(input logic [31:0] d);
    @(negedge clk);
    uvalid = 1'b1;
    udata  = d;
    @(negedge clk);
    uvalid = 1'b0;
  endtask

  initial begin
    int acks;
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_dbus", sl_dbus, 32'h0);
    chk("rst_tieoffs", {29'b0, err_ack, retry, tout}, 32'h0);
    rst_n = 1'b1;

    rd("status_reset", 32'h4, 32'h0);
    rd("data_reset", 32'h0, 32'h0);

    pulse(32'hDEADBEEF);
    rd("status_one_cap", 32'h4, 32'h9);
    rd("data_deadbeef", 32'h0, 32'hDEADBEEF);
    rd("status_after_rd", 32'h4, 32'h8);

    wr("clr1", 32'h8, 32'h1);
    rd("status_clr1", 32'h4, 32'h0);
    pulse(32'h1);
    pulse(32'h2);
    rd("status_ovf", 32'h4, 32'h13);
    rd("data_two", 32'h0, 32'h2);
    wr("clr2", 32'h8, 32'h1);
    rd("status_clr2", 32'h4, 32'h0);

    wr("freeze", 32'h8, 32'h2);
    rd("status_frozen", 32'h4, 32'h4);
    pulse(32'h55);
    rd("data_frozen", 32'h0, 32'h2);
    rd("status_frozen2", 32'h4, 32'h4);
    wr("unfreeze", 32'h8, 32'h0);
    rd("status_unfrozen", 32'h4, 32'h0);

    pulse(32'h66);
    rd("status_66", 32'h4, 32'h9);
    xfer("data_coincident", 32'h0, 1'b1, 32'h0, 32'h66, 2, 1'b1, 32'h77);
    rd("status_coincident", 32'h4, 32'h11);
    rd("data_77", 32'h0, 32'h77);
    rd("status_77_rd", 32'h4, 32'h10);

    xfer("clr_with_cap", 32'h8, 1'b0, 32'h1, 32'h0, 2, 1'b1, 32'h88);
    rd("status_clr_cap", 32'h4, 32'h9);
    rd("data_88", 32'h0, 32'h88);
    xfer("status_hold4", 32'h4, 1'b1, 32'h0, 32'h8, 4, 1'b0, 32'h0);

    acks = 0;
    @(negedge clk);
    abus = 32'h10;
    sel  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (ack) acks++;
    end
    sel = 1'b0;
    @(negedge clk);
    chk("outside_no_ack", acks, 32'd0);

    rd("idx3_read", 32'hC, 32'h0);
    wr("idx3_write", 32'hC, 32'hFFFFFFFF);
    rd("ctrl_read", 32'h8, 32'h0);
    rd("status_idx3", 32'h4, 32'h8);

    pulse(32'hA5A5A5A5);
    @(negedge clk);
    abus = 32'h4;
    rnw  = 1'b1;
    sel  = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_no_ack", {31'b0, ack}, 32'h0);
    rst_n = 1'b1;
    sb.push_back('{1'b1, 32'h0, "status_after_rst"});
    @(negedge clk);
    chk("rst_fresh_ack", {31'b0, ack}, 32'h1);
    sel = 1'b0;
    @(negedge clk);
    rd("data_after_rst", 32'h0, 32'h0);

    uvalid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      udata = i;
      @(negedge clk);
    end
    uvalid = 1'b0;
    rd("status_cnt_max", 32'h4, 32'h0007FFFB);
    rd("data_fffe", 32'h0, 32'h0000FFFE);
    pulse(32'h12345678);
    rd("status_wrap", 32'h4, 32'h3);
    rd("data_wrap", 32'h0, 32'h12345678);

    for (int i = 0; i < 10 && sb.size() != 0; i++)
      @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
